// File: rtl/mem_responder_types.sv
// Shared types for mem_responder.
//   state_e  : service FSM states
//   req_t    : one queued master request {addr, rlen, rnw, rmw, id, wbe, wdata}
//   is_write : true when a request modifies the array (plain write or rmw)
package mem_responder_types;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [4:0]  rlen;
    logic        rnw;
    logic        rmw;
    logic [1:0]  id;
    logic [3:0]  wbe;
    logic [31:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic is_write(input req_t r);
    return (~r.rnw) | r.rmw;
  endfunction

endpackage

// File: rtl/cva5_fifo.sv
// Small synchronous FIFO used as the mem_responder request queue.
//   clk, rst      : clock, asynchronous active-high reset (empties the queue)
//   push, data_in : write one entry; caller only pushes when !full
//   pop           : drop the head entry; caller only pops when valid
//   data_out      : head entry (combinational), meaningful when valid
//   valid, full   : queue non-empty / queue full (both from registered pointers)
module cva5_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // Storage is not reset; the pointers alone define which entries are live.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  assign data_out = mem_q[rd_ptr_q[PW-1:0]];
  assign valid    = (wr_ptr_q != rd_ptr_q);
  assign full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else      wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    else      rd_ptr_d = rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= data_in;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: queues master requests and services them in order against
// a word-addressed backing store.
//   clk, rst                 : clock, asynchronous active-high reset
//   request/addr/rlen/rnw/rmw/id/wbe/wdata : master request, accepted when request & ack
//   ack                      : request & ~queue_full (combinational)
//   rvalid/rid/rdata         : read-return beat (burst reads and rmw old-word beat)
//   inv/inv_addr             : one-cycle pulse on every write/rmw commit cycle
//   write_outstanding        : a write or rmw is queued or in service
module mem_responder
  import mem_responder_types::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int REQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [29:0] addr,
  input  logic [4:0]  rlen,
  input  logic        rnw,
  input  logic        rmw,
  input  logic [1:0]  id,
  input  logic [3:0]  wbe,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        rvalid,
  output logic [1:0]  rid,
  output logic [31:0] rdata,
  output logic        inv,
  output logic [29:0] inv_addr,
  output logic        write_outstanding
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(REQ_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  req_t          req_in, head;
  logic          fifo_valid, fifo_full, push, pop, start;
  state_e        state_q, state_d;
  req_t          cur_q, cur_d;
  logic [4:0]    beat_q, beat_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          rvalid_q, inv_q, wo_q;
  logic [1:0]    rid_q;
  logic [29:0]   inv_addr_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [MEM_WORDS];
  logic          rd_en, wr_en;
  logic [AW-1:0] idx;

  assign req_in = '{addr: addr, rlen: rlen, rnw: rnw, rmw: rmw, id: id, wbe: wbe, wdata: wdata};
  assign ack    = request & ~fifo_full;
  assign push   = ack;

  cva5_fifo #(.DATA_WIDTH(REQ_W), .FIFO_DEPTH(REQ_DEPTH)) u_req_q (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (req_in),
    .data_out (head),
    .valid    (fifo_valid),
    .full     (fifo_full)
  );

  // Array port controls; the index wraps naturally at MEM_WORDS.
  assign rd_en = (state_q == READ) || (state_q == RMW_RD);
  assign wr_en = (state_q == WRITE) || (state_q == RMW_WR);
  assign idx   = cur_q.addr[AW-1:0] + AW'(beat_q);

  // Service sequencing: 'start' marks a cycle that may pop the next request,
  // which includes the last cycle of every service for back-to-back operation.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    beat_d  = beat_q;
    start   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE:   start = 1'b1;
      READ: begin
        if (beat_q == cur_q.rlen) start = 1'b1;
        else                      beat_d = beat_q + 5'd1;
      end
      WRITE:  start = 1'b1;
      RMW_RD: state_d = RMW_WR;
      RMW_WR: start = 1'b1;
      default: state_d = IDLE;
    endcase
    if (start) begin
      beat_d = 5'd0;
      if (fifo_valid) begin
        pop   = 1'b1;
        cur_d = head;
        if (head.rmw)      state_d = RMW_RD;
        else if (head.rnw) state_d = READ;
        else               state_d = WRITE;
      end else begin
        state_d = IDLE;
      end
    end else begin
      cur_d = cur_q;
    end
  end

  // Count of queued entries that will modify the array.
  always_comb begin
    wcnt_d = wcnt_q;
    if ((push && is_write(req_in)) && !(pop && is_write(head)))      wcnt_d = wcnt_q + CNT_ONE;
    else if (!(push && is_write(req_in)) && (pop && is_write(head))) wcnt_d = wcnt_q - CNT_ONE;
    else                                                             wcnt_d = wcnt_q;
  end

  // FSM state, in-service request and registered outputs. inv and
  // write_outstanding are registered from next-state values so they line up
  // with the commit cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      beat_q     <= 5'd0;
      wcnt_q     <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= 2'd0;
      inv_q      <= 1'b0;
      inv_addr_q <= 30'd0;
      wo_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      beat_q     <= beat_d;
      wcnt_q     <= wcnt_d;
      rvalid_q   <= rd_en;
      rid_q      <= cur_q.id;
      inv_q      <= (state_d == WRITE) || (state_d == RMW_WR);
      inv_addr_q <= cur_d.addr;
      wo_q       <= (wcnt_d != '0) || (state_d == WRITE) || (state_d == RMW_RD) || (state_d == RMW_WR);
    end
  end

  // Backing store: 1-cycle registered read, byte-enabled write; not reset.
  always_ff @(posedge clk) begin
    if (rd_en) rdata_q <= mem_q[idx];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_q.wbe[i]) mem_q[idx][8*i +: 8] <= cur_q.wdata[8*i +: 8];
      end
    end
  end

  assign rvalid            = rvalid_q;
  assign rid               = rid_q;
  assign rdata             = rdata_q;
  assign inv               = inv_q;
  assign inv_addr          = inv_addr_q;
  assign write_outstanding = wo_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk, rst, request, rnw, rmw, ack, rvalid, inv, write_outstanding;
  logic [29:0] addr, inv_addr;
  logic [4:0]  rlen;
  logic [1:0]  id, rid;
  logic [3:0]  wbe;
  logic [31:0] wdata, rdata;

  mem_responder #(.MEM_WORDS(16), .REQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .request(request), .addr(addr), .rlen(rlen), .rnw(rnw),
    .rmw(rmw), .id(id), .wbe(wbe), .wdata(wdata), .ack(ack), .rvalid(rvalid),
    .rid(rid), .rdata(rdata), .inv(inv), .inv_addr(inv_addr),
    .write_outstanding(write_outstanding)
  );

  typedef struct { logic [1:0] id; logic [31:0] data; int cyc; } beat_t;
  beat_t       beats[$];
  int          errs = 0, checks = 0, cyc = 0, inv_cnt = 0, last_inv_cyc = 0, last_wo_cyc = 0;
  logic [29:0] last_inv_addr = 30'd0;
  logic [31:0] mirror [16];

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rvalid) beats.push_back('{rid, rdata, cyc});
    if (inv) begin inv_cnt++; last_inv_addr = inv_addr; last_inv_cyc = cyc; end
    if (write_outstanding) last_wo_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one request from just after a rising edge; returns the cycle in which it was accepted.
  task automatic send(input logic [29:0] a, input logic [4:0] len, input logic nw, input logic m,
                      input logic [1:0] i, input logic [3:0] be, input logic [31:0] wd, output int acc);
    bit got = 1'b0;
    acc = -1;
    request = 1'b1; addr = a; rlen = len; rnw = nw; rmw = m; id = i; wbe = be; wdata = wd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; acc = cyc; break; end
      @(posedge clk); #1;
    end
    if (!got) check_eq("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    request = 1'b0;
    if (!nw || m) begin
      for (int b = 0; b < 4; b++) if (be[b]) mirror[a[3:0]][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int a, acc, inv0;
  logic [31:0] exp_d [21];
  logic [1:0]  exp_id [21];

  initial begin
    rst = 1'b1; request = 1'b0; addr = 30'd0; rlen = 5'd0; rnw = 1'b0; rmw = 1'b0;
    id = 2'd0; wbe = 4'd0; wdata = 32'd0;
    #2;
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_inv", inv, 1'b0);
    check_eq("rst_wo", write_outstanding, 1'b0);
    check_eq("rst_rid", rid, 2'd0);
    check_eq("rst_ack_idle", ack, 1'b0);
    request = 1'b1; #1;
    check_eq("rst_ack_empty", ack, 1'b1);
    request = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Fill the array with known words.
    for (int k = 0; k < 16; k++) send(30'(k), 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hC0DE0000 + k, acc);
    for (int k = 0; k < 4; k++) send(30'(8 + k), 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h11111111 * (k + 1), acc);
    drain(10);
    check_eq("init_inv_count", inv_cnt, 20);
    check_eq("init_inv_addr", last_inv_addr, 30'd11);

    // Read burst idx 8..11.
    beats.delete();
    send(30'd8, 5'd3, 1'b1, 1'b0, 2'd1, 4'h0, 32'd0, a);
    drain(12);
    check_eq("burst_count", beats.size(), 4);
    for (int k = 0; k < 4; k++) if (beats.size() > k) begin
      check_eq("burst_data", beats[k].data, 32'h11111111 * (k + 1));
      check_eq("burst_rid", beats[k].id, 2'd1);
      check_eq("burst_cyc", beats[k].cyc, a + 3 + k);
    end

    // Byte-enable write.
    send(30'd3, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hAABBCCDD, acc);
    drain(6);
    inv0 = inv_cnt;
    send(30'd3, 5'd7, 1'b0, 1'b0, 2'd0, 4'b0101, 32'h11223344, a);
    check_eq("bw_wo_high", write_outstanding, 1'b1);
    drain(6);
    check_eq("bw_inv_once", inv_cnt - inv0, 1);
    check_eq("bw_inv_addr", last_inv_addr, 30'd3);
    check_eq("bw_inv_cyc", last_inv_cyc, a + 2);
    check_eq("bw_wo_last", last_wo_cyc, a + 2);
    check_eq("bw_wo_low", write_outstanding, 1'b0);
    beats.delete();
    send(30'd3, 5'd0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, a);
    drain(6);
    check_eq("bw_count", beats.size(), 1);
    if (beats.size() > 0) check_eq("bw_data", beats[0].data, 32'hAA22CC44);

    // Wrap: idx 14,15,0,1.
    send(30'd14, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h000000AE, acc);
    send(30'd15, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h000000AF, acc);
    send(30'd0,  5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h000000A0, acc);
    send(30'd1,  5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h000000A1, acc);
    drain(8);
    beats.delete();
    send(30'd14, 5'd3, 1'b1, 1'b0, 2'd3, 4'h0, 32'd0, a);
    drain(10);
    check_eq("wrap_count", beats.size(), 4);
    exp_d[0] = 32'hAE; exp_d[1] = 32'hAF; exp_d[2] = 32'hA0; exp_d[3] = 32'hA1;
    for (int k = 0; k < 4; k++) if (beats.size() > k) begin
      check_eq("wrap_data", beats[k].data, exp_d[k]);
      check_eq("wrap_rid", beats[k].id, 2'd3);
    end

    // Full queue behind a 16-beat read.
    beats.delete();
    for (int k = 0; k < 16; k++) begin exp_d[k] = mirror[k]; exp_id[k] = 2'd0; end
    exp_d[16] = mirror[8];  exp_id[16] = 2'd1;
    exp_d[17] = mirror[9];  exp_id[17] = 2'd2;
    exp_d[18] = mirror[10]; exp_id[18] = 2'd3;
    exp_d[19] = mirror[11]; exp_id[19] = 2'd0;
    exp_d[20] = mirror[3];  exp_id[20] = 2'd2;
    send(30'd0, 5'd15, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0, a);
    send(30'd8,  5'd0, 1'b1, 1'b0, 2'd1, 4'h0, 32'd0, acc);
    send(30'd9,  5'd0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, acc);
    send(30'd10, 5'd0, 1'b1, 1'b0, 2'd3, 4'h0, 32'd0, acc);
    send(30'd11, 5'd0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0, acc);
    check_eq("full_fourth_acc", acc, a + 4);
    send(30'd3,  5'd0, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, acc);
    check_eq("full_fifth_acc", acc, a + 18);
    drain(20);
    check_eq("full_count", beats.size(), 21);
    for (int k = 0; k < 21; k++) if (beats.size() > k) begin
      check_eq("full_data", beats[k].data, exp_d[k]);
      check_eq("full_rid", beats[k].id, exp_id[k]);
      check_eq("full_cyc", beats[k].cyc, a + 3 + k);
    end

    // Read-modify-write with a read queued behind it.
    send(30'd5, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h00000005, acc);
    drain(6);
    beats.delete();
    inv0 = inv_cnt;
    send(30'd5, 5'd0, 1'b0, 1'b1, 2'd2, 4'hF, 32'h00000009, a);
    send(30'd5, 5'd0, 1'b1, 1'b0, 2'd0, 4'h0, 32'd0, acc);
    drain(8);
    check_eq("rmw_count", beats.size(), 2);
    if (beats.size() > 1) begin
      check_eq("rmw_old", beats[0].data, 32'h5);
      check_eq("rmw_rid", beats[0].id, 2'd2);
      check_eq("rmw_cyc", beats[0].cyc, a + 3);
      check_eq("rmw_new", beats[1].data, 32'h9);
      check_eq("rmw_new_rid", beats[1].id, 2'd0);
    end
    check_eq("rmw_inv_once", inv_cnt - inv0, 1);
    check_eq("rmw_inv_addr", last_inv_addr, 30'd5);

    // Reset in the middle of an 8-beat read.
    beats.delete();
    send(30'd0, 5'd7, 1'b1, 1'b0, 2'd1, 4'h0, 32'd0, a);
    for (int n = 0; n < 50 && beats.size() < 2; n++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mrst_rvalid", rvalid, 1'b0);
    check_eq("mrst_inv", inv, 1'b0);
    check_eq("mrst_wo", write_outstanding, 1'b0);
    check_eq("mrst_rid", rid, 2'd0);
    drain(2);
    rst = 1'b0;
    drain(3);
    check_eq("mrst_beats", beats.size(), 2);
    if (beats.size() > 1) check_eq("mrst_beat1", beats[1].data, mirror[1]);
    beats.delete();
    send(30'd2, 5'd1, 1'b1, 1'b0, 2'd2, 4'h0, 32'd0, a);
    drain(8);
    check_eq("post_count", beats.size(), 2);
    for (int k = 0; k < 2; k++) if (beats.size() > k) begin
      check_eq("post_data", beats[k].data, mirror[2 + k]);
      check_eq("post_rid", beats[k].id, 2'd2);
      check_eq("post_cyc", beats[k].cyc, a + 3 + k);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
